// File: rtl/alarm_sequencer.sv
// Alarm sequencer: watches the countdown timer and sounds a beep pattern when it expires.
//
// Expiry is a falling edge of IS_RUNNING while CNT_ZERO is high. The alarm then plays
// bursts of BEEPS_PER_BURST beeps (BEEP_ON_MS on, BEEP_OFF_MS off), separated by
// BURST_GAP_MS of silence, for MAX_BURSTS bursts, then returns to idle with a TIMEOUT pulse.
// ACK or a timer restart (rising edge of IS_RUNNING) silences it immediately.
//
// Ports:
//   CLK        clock
//   CLR        synchronous active-high reset, overrides CE
//   CE         global enable; everything holds while low
//   MS_CE      1 ms tick, one CLK wide, counted only when CE=1
//   IS_RUNNING countdown timer running flag
//   CNT_ZERO   timer seconds value is zero
//   ACK        silence request, single-cycle pulse
//   BUZZ       tone-modulated buzzer drive
//   BEEP       beep envelope
//   ACTIVE     alarm sequence in progress
//   TIMEOUT    one-cycle pulse when the sequence ends on its own
module alarm_sequencer #(
  parameter int unsigned TONE_HALF_PERIOD = 25000,
  parameter int unsigned BEEP_ON_MS       = 150,
  parameter int unsigned BEEP_OFF_MS      = 100,
  parameter int unsigned BEEPS_PER_BURST  = 4,
  parameter int unsigned BURST_GAP_MS     = 1000,
  parameter int unsigned MAX_BURSTS       = 30
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CE,
  input  logic MS_CE,
  input  logic IS_RUNNING,
  input  logic CNT_ZERO,
  input  logic ACK,
  output logic BUZZ,
  output logic BEEP,
  output logic ACTIVE,
  output logic TIMEOUT
);

  localparam int unsigned MsMax01 = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
  localparam int unsigned MsMax   = (MsMax01 > BURST_GAP_MS) ? MsMax01 : BURST_GAP_MS;
  localparam int unsigned MsW     = $clog2(MsMax + 1);
  localparam int unsigned BeepW   = $clog2(BEEPS_PER_BURST + 1);
  localparam int unsigned BurstW  = $clog2(MAX_BURSTS + 1);
  localparam int unsigned ToneW   = $clog2(TONE_HALF_PERIOD + 1);

  localparam logic [MsW-1:0]    OnLast    = MsW'(BEEP_ON_MS - 1);
  localparam logic [MsW-1:0]    OffLast   = MsW'(BEEP_OFF_MS - 1);
  localparam logic [MsW-1:0]    GapLast   = MsW'(BURST_GAP_MS - 1);
  localparam logic [BeepW-1:0]  BeepLast  = BeepW'(BEEPS_PER_BURST - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURSTS - 1);
  localparam logic [ToneW-1:0]  ToneLast  = ToneW'(TONE_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBeepOn,
    StBeepOff,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic              run_q, run_d;
  logic [MsW-1:0]    ms_cnt_q, ms_cnt_d;
  logic [BeepW-1:0]  beep_idx_q, beep_idx_d;
  logic [BurstW-1:0] burst_idx_q, burst_idx_d;
  logic [ToneW-1:0]  tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;
  logic              timeout_q, timeout_d;

  logic tick, expire, restart, stop;
  // Set whenever an interval starts afresh: clears the ms counter and the tone phase.
  logic enter;

  assign tick    = CE & MS_CE;
  assign expire  = CE & run_q & ~IS_RUNNING & CNT_ZERO;
  assign restart = CE & ~run_q & IS_RUNNING;
  assign stop    = CE & (ACK | restart);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    ms_cnt_d    = ms_cnt_q;
    beep_idx_d  = beep_idx_q;
    burst_idx_d = burst_idx_q;
    tone_cnt_d  = tone_cnt_q;
    tone_d      = tone_q;
    timeout_d   = timeout_q;
    enter       = 1'b0;

    if (CE) begin
      run_d     = IS_RUNNING;
      timeout_d = 1'b0;

      if (stop) begin
        if (state_q != StIdle) begin
          state_d     = StIdle;
          beep_idx_d  = '0;
          burst_idx_d = '0;
          enter       = 1'b1;
        end
      end else if (expire) begin
        // Also restarts a sequence already in progress.
        state_d     = StBeepOn;
        beep_idx_d  = '0;
        burst_idx_d = '0;
        enter       = 1'b1;
      end else if (tick) begin
        unique case (state_q)
          StIdle: ;
          StBeepOn: begin
            if (ms_cnt_q == OnLast) begin
              enter   = 1'b1;
              state_d = (beep_idx_q == BeepLast) ? StGap : StBeepOff;
            end
          end
          StBeepOff: begin
            if (ms_cnt_q == OffLast) begin
              enter      = 1'b1;
              state_d    = StBeepOn;
              beep_idx_d = beep_idx_q + 1'b1;
            end
          end
          StGap: begin
            if (ms_cnt_q == GapLast) begin
              enter      = 1'b1;
              beep_idx_d = '0;
              if (burst_idx_q == BurstLast) begin
                state_d     = StIdle;
                burst_idx_d = '0;
                timeout_d   = 1'b1;
              end else begin
                state_d     = StBeepOn;
                burst_idx_d = burst_idx_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      if (enter || state_q == StIdle) begin
        ms_cnt_d = '0;
      end else if (tick) begin
        ms_cnt_d = ms_cnt_q + 1'b1;
      end

      // Tone only advances inside a beep; each beep begins in the low phase.
      if (enter || state_q != StBeepOn) begin
        tone_cnt_d = '0;
        tone_d     = 1'b0;
      end else if (tone_cnt_q == ToneLast) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= StIdle;
      run_q       <= 1'b0;
      ms_cnt_q    <= '0;
      beep_idx_q  <= '0;
      burst_idx_q <= '0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      ms_cnt_q    <= ms_cnt_d;
      beep_idx_q  <= beep_idx_d;
      burst_idx_q <= burst_idx_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
      timeout_q   <= timeout_d;
    end
  end

  assign BEEP    = (state_q == StBeepOn);
  assign ACTIVE  = (state_q != StIdle);
  assign BUZZ    = tone_q & BEEP;
  assign TIMEOUT = timeout_q;

endmodule
